// File: rtl/featuremap_sum_pipe.sv
// Channel summation for one output feature map: a registered adder tree, then bias add,
// then activation with saturation, with a pixel counter that flags the last pixel of each frame.
module featuremap_sum_pipe #(
    parameter int                           NUM_CH     = 32,
    parameter int                           DATA_WIDTH = 16,
    parameter int                           FRAC_BITS  = 8,
    parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0,
    parameter int                           ACT_MODE   = 1,
    parameter int                           IMG_SIZE   = 104
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in_i,
    input  logic                         valid_in_i,
    output logic [DATA_WIDTH-1:0]        data_out_o,
    output logic                         valid_out_o,
    output logic                         last_out_o
);

    localparam int T         = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int N0        = 1 << T;
    localparam int ACC_W     = DATA_WIDTH + T + 1;
    localparam int L         = T + 2;
    localparam int FRAME_PIX = IMG_SIZE * IMG_SIZE;
    localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (NUM_CH < 1 || IMG_SIZE < 1 || ACT_MODE < 0 || ACT_MODE > 2 ||
        FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
        $error("featuremap_sum_pipe: illegal parameter combination");
    end

    // Balanced tree over N0 leaves; leaves past NUM_CH are tied to zero, so an odd
    // operand out at any level is simply summed with zero.
    for (genvar l = 0; l <= T; l++) begin : g_lvl
        localparam int W = 1 << (T - l);
        logic signed [ACC_W-1:0] node [W];

        if (l == 0) begin : g_leaf
            for (genvar c = 0; c < W; c++) begin : g_ch
                if (c < NUM_CH) begin : g_in
                    assign node[c] = ACC_W'(signed'(data_in_i[c*DATA_WIDTH +: DATA_WIDTH]));
                end else begin : g_pad
                    assign node[c] = '0;
                end
            end
        end else begin : g_add
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < W; i++) begin
                        node[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < W; i++) begin
                        node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
                    end
                end
            end
        end
    end

    logic signed [ACC_W-1:0] tree_out;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [ACC_W-1:0] act_d;
    logic [DATA_WIDTH-1:0]   data_out_d, data_out_q;
    logic [L-1:0]            vld_d, vld_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic                    last_pix;

    assign tree_out = g_lvl[T].node[0];
    assign acc_d    = tree_out + ACC_W'(signed'(BIAS));

    always_comb begin
        act_d = acc_q;
        if (acc_q[ACC_W-1]) begin
            if (ACT_MODE == 1) begin
                act_d = acc_q >>> 3;
            end else if (ACT_MODE == 2) begin
                act_d = '0;
            end
        end

        if (act_d > SAT_MAX) begin
            data_out_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (act_d < SAT_MIN) begin
            data_out_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            data_out_d = act_d[DATA_WIDTH-1:0];
        end
    end

    // The data path free-runs every cycle; only the valid shift register qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            data_out_q <= '0;
        end else begin
            acc_q      <= acc_d;
            data_out_q <= data_out_d;
        end
    end

    assign last_pix = vld_q[L-1] && (cnt_q == CNT_LAST);

    always_comb begin
        vld_d = {vld_q[L-2:0], valid_in_i};
        cnt_d = cnt_q;
        if (clr_i) begin
            vld_d = '0;
            cnt_d = '0;
        end else if (last_pix) begin
            cnt_d = '0;
        end else if (vld_q[L-1]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign data_out_o  = data_out_q;
    assign valid_out_o = vld_q[L-1];
    assign last_out_o  = last_pix;

endmodule

// File: tb/tb_featuremap_sum_pipe.sv
// Bench for featuremap_sum_pipe: five parameterisations share one stimulus bus; table vectors
// check the arithmetic and latency, and hand-written streams check frame tracking, reset and clr.
module tb_featuremap_sum_pipe;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr   = 1'b0;
    logic         valid = 1'b0;
    logic [511:0] din   = '0;

    logic        vout [5];
    logic        lout [5];
    logic [15:0] dout [5];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // 0: linear, frame of 2x2   1: leaky + bias   2: relu + bias   3: 5 channels   4: 1 channel leaky
    featuremap_sum_pipe #(.NUM_CH(32), .DATA_WIDTH(16), .FRAC_BITS(8), .BIAS(16'sh0000),
                          .ACT_MODE(0), .IMG_SIZE(2)) u_lin (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_in_i(din), .valid_in_i(valid),
        .data_out_o(dout[0]), .valid_out_o(vout[0]), .last_out_o(lout[0]));

    featuremap_sum_pipe #(.NUM_CH(32), .DATA_WIDTH(16), .FRAC_BITS(8), .BIAS(16'sh0100),
                          .ACT_MODE(1), .IMG_SIZE(104)) u_lky (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_in_i(din), .valid_in_i(valid),
        .data_out_o(dout[1]), .valid_out_o(vout[1]), .last_out_o(lout[1]));

    featuremap_sum_pipe #(.NUM_CH(32), .DATA_WIDTH(16), .FRAC_BITS(8), .BIAS(16'sh0100),
                          .ACT_MODE(2), .IMG_SIZE(104)) u_rlu (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_in_i(din), .valid_in_i(valid),
        .data_out_o(dout[2]), .valid_out_o(vout[2]), .last_out_o(lout[2]));

    featuremap_sum_pipe #(.NUM_CH(5), .DATA_WIDTH(16), .FRAC_BITS(8), .BIAS(16'sh0000),
                          .ACT_MODE(0), .IMG_SIZE(104)) u_odd (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_in_i(din[79:0]), .valid_in_i(valid),
        .data_out_o(dout[3]), .valid_out_o(vout[3]), .last_out_o(lout[3]));

    featuremap_sum_pipe #(.NUM_CH(1), .DATA_WIDTH(16), .FRAC_BITS(8), .BIAS(16'sh0000),
                          .ACT_MODE(1), .IMG_SIZE(104)) u_one (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .data_in_i(din[15:0]), .valid_in_i(valid),
        .data_out_o(dout[4]), .valid_out_o(vout[4]), .last_out_o(lout[4]));

    typedef struct {
        logic [15:0]       base;
        logic [15:0]       step;
        logic [0:4][15:0]  exp;
    } vec_t;

    vec_t        vecs [10];
    int          lat_exp [5] = '{7, 7, 7, 5, 2};
    int          seen [5];
    int          lat [5];
    logic [15:0] got [5];
    logic [63:0] omask, lmask;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] base, input logic [15:0] step);
        for (int c = 0; c < 32; c++) begin
            din[c*16 +: 16] = base + 16'(c) * step;
        end
    endtask

    // Drives pattern bit k at negedge k and records u_lin outputs; sample index k
    // corresponds to the output sampled at that same negedge before new drive.
    task automatic stream(input logic [31:0] pat, input int rst_at, input int clr_at,
                          input bit clr_on_last, output logic [63:0] om, output logic [63:0] lm);
        om = '0;
        lm = '0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (vout[0]) begin
                om[k] = 1'b1;
                chk($sformatf("stream data @%0d", k), 64'(dout[0]), 64'h2000);
            end
            if (lout[0]) lm[k] = 1'b1;
            valid = (k < 32) ? pat[k] : 1'b0;
            clr   = (k == clr_at) || (clr_on_last && lout[0]);
            rst_n = (k != rst_at);
        end
        valid = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0000, {16'h2000, 16'h2100, 16'h2100, 16'h0500, 16'h0100}};
        vecs[1] = '{16'hFF00, 16'h0000, {16'hE000, 16'hFC20, 16'h0000, 16'hFB00, 16'hFFE0}};
        vecs[2] = '{16'h7FFF, 16'h0000, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}};
        vecs[3] = '{16'h8000, 16'h0000, {16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'hF000}};
        vecs[4] = '{16'h0000, 16'h0001, {16'h01F0, 16'h02F0, 16'h02F0, 16'h000A, 16'h0000}};
        vecs[5] = '{16'hFFF0, 16'h0001, {16'hFFF0, 16'h00F0, 16'h00F0, 16'hFFBA, 16'hFFFE}};
        vecs[6] = '{16'hFE00, 16'h0000, {16'hC000, 16'hF820, 16'h0000, 16'hF600, 16'hFFC0}};
        vecs[7] = '{16'hFFF9, 16'h0000, {16'hFF20, 16'h0020, 16'h0020, 16'hFFDD, 16'hFFFF}};
        vecs[8] = '{16'h0100, 16'h0100, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0F00, 16'h0100}};
        vecs[9] = '{16'hFFE0, 16'h0000, {16'hFC00, 16'hFFA0, 16'h0000, 16'hFF60, 16'hFFFC}};

        // Reset held with live stimulus: every output must stay at zero.
        set_all(16'h0100, 16'h0000);
        valid = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("reset valid_out inst%0d", i), 64'(vout[i]), 64'h0);
            chk($sformatf("reset last_out inst%0d", i), 64'(lout[i]), 64'h0);
            chk($sformatf("reset data_out inst%0d", i), 64'(dout[i]), 64'h0);
        end
        valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            set_all(vecs[v].base, vecs[v].step);
            valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                seen[i] = 0;
                lat[i]  = -1;
                got[i]  = 16'h0;
            end
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                valid = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    if (vout[i]) begin
                        seen[i]++;
                        lat[i] = k;
                        got[i] = dout[i];
                    end
                end
            end
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("vec%0d inst%0d valid count", v, i), 64'(seen[i]), 64'd1);
                chk($sformatf("vec%0d inst%0d latency", v, i), 64'(lat[i]), 64'(lat_exp[i]));
                chk($sformatf("vec%0d inst%0d data", v, i), 64'(got[i]), 64'(vecs[v].exp[i]));
            end
        end

        set_all(16'h0100, 16'h0000);

        // Three pixels in flight when reset pulses: none of them may emerge.
        stream(32'h7, 4, -1, 1'b0, omask, lmask);
        chk("reset flush valid", omask, 64'h0);
        chk("reset flush last", lmask, 64'h0);

        // Ten back-to-back pixels after reset: frame of four, last on outputs 4 and 8.
        stream(32'h3FF, -1, -1, 1'b0, omask, lmask);
        chk("frame valid", omask, 64'h3FF << 7);
        chk("frame last", lmask, (64'h1 << 10) | (64'h1 << 14));

        // Gaps propagate unchanged; counter resumes at 2, so the second pixel is last.
        stream(32'h165, -1, -1, 1'b0, omask, lmask);
        chk("gap valid", omask, 64'h165 << 7);
        chk("gap last", lmask, 64'h1 << 9);

        stream(32'h1, -1, 0, 1'b0, omask, lmask);
        chk("clr with valid_in", omask, 64'h0);

        stream(32'h3, -1, 3, 1'b0, omask, lmask);
        chk("clr in flight", omask, 64'h0);

        stream(32'hF, -1, -1, 1'b0, omask, lmask);
        chk("post clr valid", omask, 64'hF << 7);
        chk("post clr last", lmask, 64'h1 << 10);

        // clr during the last pixel flushes the two trailing pixels and restarts at zero.
        stream(32'h3F, -1, -1, 1'b1, omask, lmask);
        chk("clr on last valid", omask, 64'hF << 7);
        chk("clr on last last", lmask, 64'h1 << 10);

        stream(32'hF, -1, -1, 1'b0, omask, lmask);
        chk("after clr on last valid", omask, 64'hF << 7);
        chk("after clr on last last", lmask, 64'h1 << 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
